// File: rtl/vga_ball_renderer.sv
// VGA raster engine: H/V timing counters, sync generation, striped background and a square
// ball that bounces off the screen edges once per frame. All outputs share a 2-clock pipeline.
`timescale 1ns/1ps
module vga_ball_renderer #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned SYNC_POL   = 0,
   parameter int unsigned COLOR_BITS = 4,
   parameter int unsigned BALL_SIZE  = 12,
   parameter int unsigned BALL_X0    = 100,
   parameter int unsigned BALL_Y0    = 100,
   parameter int unsigned BALL_DX    = 2,
   parameter int unsigned BALL_DY    = 1
) (
   input  logic                  iVGA_CLK,
   input  logic                  iRST_n,
   input  logic                  iRUN,
   output logic                  oHS,
   output logic                  oVS,
   output logic                  oBLANK_n,
   output logic [COLOR_BITS-1:0] oVGA_R,
   output logic [COLOR_BITS-1:0] oVGA_G,
   output logic [COLOR_BITS-1:0] oVGA_B,
   output logic                  oFRAME
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned DXW     = $clog2(BALL_DX + 1) + 1;
   localparam int unsigned DYW     = $clog2(BALL_DY + 1) + 1;

   localparam logic          SYNC_ACT  = 1'(SYNC_POL);
   localparam logic [HW:0]   H_ACT_E   = (HW+1)'(H_ACTIVE);
   localparam logic [HW:0]   HS_BEG    = (HW+1)'(H_ACTIVE + H_FP);
   localparam logic [HW:0]   HS_END    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW:0]   H_THIRD   = (HW+1)'(H_ACTIVE / 3);
   localparam logic [HW:0]   H_2THIRD  = (HW+1)'((2 * H_ACTIVE) / 3);
   localparam logic [HW:0]   X_MAX     = (HW+1)'(H_ACTIVE - BALL_SIZE);
   localparam logic [HW:0]   BALL_W    = (HW+1)'(BALL_SIZE);
   localparam logic [VW:0]   V_ACT_E   = (VW+1)'(V_ACTIVE);
   localparam logic [VW:0]   VS_BEG    = (VW+1)'(V_ACTIVE + V_FP);
   localparam logic [VW:0]   VS_END    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW:0]   Y_MAX     = (VW+1)'(V_ACTIVE - BALL_SIZE);
   localparam logic [VW:0]   BALL_H    = (VW+1)'(BALL_SIZE);

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [HW:0]   hx;
   logic [VW:0]   vy;
   logic          h_last;

   // Raster position counters
   assign h_last = (hcnt == HW'(H_TOTAL - 1));
   assign hx     = {1'b0, hcnt};
   assign vy     = {1'b0, vcnt};

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (h_last) begin
         hcnt <= '0;
         vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
      end else begin
         hcnt <= hcnt + HW'(1);
      end
   end

   logic [HW-1:0]         bx, bx_n;
   logic [VW-1:0]         by, by_n;
   logic signed [DXW-1:0] dx, dx_n;
   logic signed [DYW-1:0] dy, dy_n;
   logic [HW:0]           bx_ext, dx_mag, bx_sum;
   logic [VW:0]           by_ext, dy_mag, by_sum;
   logic                  tick_c;

   assign bx_ext = {1'b0, bx};
   assign by_ext = {1'b0, by};
   assign tick_c = (hcnt == '0) && (vy == V_ACT_E);

   // Next ball position; compares run one bit wider so the sums cannot wrap
   always_comb begin
      bx_n   = bx;
      dx_n   = dx;
      by_n   = by;
      dy_n   = dy;
      dx_mag = (HW+1)'($unsigned(dx[DXW-1] ? -dx : dx));
      dy_mag = (VW+1)'($unsigned(dy[DYW-1] ? -dy : dy));
      bx_sum = bx_ext + dx_mag;
      by_sum = by_ext + dy_mag;

      if (!dx[DXW-1]) begin
         if (bx_sum >= X_MAX) begin
            bx_n = X_MAX[HW-1:0];
            dx_n = -dx;
         end else begin
            bx_n = bx_sum[HW-1:0];
         end
      end else if (bx_ext <= dx_mag) begin
         bx_n = '0;
         dx_n = -dx;
      end else begin
         bx_n = bx - dx_mag[HW-1:0];
      end

      if (!dy[DYW-1]) begin
         if (by_sum >= Y_MAX) begin
            by_n = Y_MAX[VW-1:0];
            dy_n = -dy;
         end else begin
            by_n = by_sum[VW-1:0];
         end
      end else if (by_ext <= dy_mag) begin
         by_n = '0;
         dy_n = -dy;
      end else begin
         by_n = by - dy_mag[VW-1:0];
      end
   end

   // Ball only moves at the frame tick, which lies in vertical blanking
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         bx <= HW'(BALL_X0);
         by <= VW'(BALL_Y0);
         dx <= DXW'(BALL_DX);
         dy <= DYW'(BALL_DY);
      end else if (tick_c && iRUN) begin
         bx <= bx_n;
         by <= by_n;
         dx <= dx_n;
         dy <= dy_n;
      end
   end

   logic                  active_c, hs_c, vs_c, hit_c;
   logic [COLOR_BITS-1:0] r_c, g_c, b_c;

   assign active_c = (hx < H_ACT_E) && (vy < V_ACT_E);
   assign hs_c     = (hx >= HS_BEG && hx < HS_END) ? SYNC_ACT : ~SYNC_ACT;
   assign vs_c     = (vy >= VS_BEG && vy < VS_END) ? SYNC_ACT : ~SYNC_ACT;
   assign hit_c    = (hx >= bx_ext) && (hx < bx_ext + BALL_W) &&
                     (vy >= by_ext) && (vy < by_ext + BALL_H);

   // Pixel colour: blank, ball, then blue/green/red thirds
   always_comb begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
      if (active_c) begin
         if (hit_c) begin
            r_c = '1;
            g_c = '1;
            b_c = '1;
         end else if (hx < H_THIRD) begin
            b_c = '1;
         end else if (hx < H_2THIRD) begin
            g_c = '1;
         end else begin
            r_c = '1;
         end
      end
   end

   logic                  active_s1, hs_s1, vs_s1, frame_s1;
   logic [COLOR_BITS-1:0] r_s1, g_s1, b_s1;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         active_s1 <= 1'b0;
         hs_s1     <= ~SYNC_ACT;
         vs_s1     <= ~SYNC_ACT;
         frame_s1  <= 1'b0;
         r_s1      <= '0;
         g_s1      <= '0;
         b_s1      <= '0;
      end else begin
         active_s1 <= active_c;
         hs_s1     <= hs_c;
         vs_s1     <= vs_c;
         frame_s1  <= tick_c;
         r_s1      <= r_c;
         g_s1      <= g_c;
         b_s1      <= b_c;
      end
   end

   // Output stage
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oBLANK_n <= 1'b0;
         oHS      <= ~SYNC_ACT;
         oVS      <= ~SYNC_ACT;
         oFRAME   <= 1'b0;
         oVGA_R   <= '0;
         oVGA_G   <= '0;
         oVGA_B   <= '0;
      end else begin
         oBLANK_n <= active_s1;
         oHS      <= hs_s1;
         oVS      <= vs_s1;
         oFRAME   <= frame_s1;
         oVGA_R   <= r_s1;
         oVGA_G   <= g_s1;
         oVGA_B   <= b_s1;
      end
   end

endmodule
